// File: rtl/axi_chdr_framer.sv
// axi_chdr_framer: turns a continuous 64-bit sample stream into CHDR packets.
// Each packet is a generated header word, an optional timestamp word, then
// spp payload words. The last payload word carries o_tlast.
// Optional feature macro: CHDR_FRAMER_TIME_EN
//   defined   -> vita_time port exists, has_time=1, a TIME word follows each header
//   undefined -> no vita_time port, header is followed directly by payload
module axi_chdr_framer #(
  parameter int         WIDTH    = 64,
  parameter logic [1:0] PKT_TYPE = 2'b00
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [31:0]      sid,
  input  logic [15:0]      spp,
`ifdef CHDR_FRAMER_TIME_EN
  input  logic [63:0]      vita_time,
`endif
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready
);

`ifdef CHDR_FRAMER_TIME_EN
  localparam logic HAS_TIME = 1'b1;
  typedef enum logic [1:0] {S_HEADER, S_TIME, S_PAYLOAD} state_t;
`else
  localparam logic HAS_TIME = 1'b0;
  typedef enum logic [1:0] {S_HEADER, S_PAYLOAD} state_t;
`endif

  state_t      state_q, state_d;
  logic [11:0] seqnum_q, seqnum_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] spp_q, spp_d;
`ifdef CHDR_FRAMER_TIME_EN
  logic [63:0] time_q, time_d;
`endif

  logic        soft_rst;
  logic        hs;
  logic        last_word;
  logic [15:0] spp_eff;
  logic [15:0] pkt_len;
  logic [63:0] hdr_word;

  assign soft_rst = reset | clear;
  assign hs       = o_tvalid & o_tready;

  // spp of zero still carries one payload word; length wraps modulo 2^16.
  // The header is built from the live sid/spp because it is emitted in the
  // very cycle those inputs are sampled; only spp is needed afterwards.
  always_comb begin
    spp_eff   = (spp == 16'd0) ? 16'd1 : spp;
    pkt_len   = (spp_eff + 16'd1 + {15'd0, HAS_TIME}) << 3;
    hdr_word  = {PKT_TYPE, HAS_TIME, 1'b0, seqnum_q, pkt_len, sid};
    last_word = (cnt_q == (spp_q - 16'd1));
  end

  // State and packet bookkeeping registers; reset and clear act identically.
  always_ff @(posedge clk) begin
    if (soft_rst) begin
      state_q  <= S_HEADER;
      seqnum_q <= '0;
      cnt_q    <= '0;
      spp_q    <= '0;
`ifdef CHDR_FRAMER_TIME_EN
      time_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      seqnum_q <= seqnum_d;
      cnt_q    <= cnt_d;
      spp_q    <= spp_d;
`ifdef CHDR_FRAMER_TIME_EN
      time_q   <= time_d;
`endif
    end
  end

  // Next-state logic: advance on each output handshake.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_HEADER: begin
        if (hs) begin
`ifdef CHDR_FRAMER_TIME_EN
          state_d = S_TIME;
`else
          state_d = S_PAYLOAD;
`endif
        end
      end
`ifdef CHDR_FRAMER_TIME_EN
      S_TIME: begin
        if (hs) state_d = S_PAYLOAD;
      end
`endif
      S_PAYLOAD: begin
        if (hs && last_word) state_d = S_HEADER;
      end
      default: state_d = S_HEADER;
    endcase
  end

  // Latch per-packet parameters at the header, count payload handshakes.
  always_comb begin
    seqnum_d = seqnum_q;
    cnt_d    = cnt_q;
    spp_d    = spp_q;
`ifdef CHDR_FRAMER_TIME_EN
    time_d   = time_q;
`endif
    if (state_q == S_HEADER && hs) begin
      seqnum_d = seqnum_q + 12'd1;
      cnt_d    = '0;
      spp_d    = spp_eff;
`ifdef CHDR_FRAMER_TIME_EN
      time_d   = vita_time;
`endif
    end
    if (state_q == S_PAYLOAD && hs) begin
      cnt_d = last_word ? '0 : (cnt_q + 16'd1);
    end
  end

  // Output decode; handshake paths are combinational, reset masks them.
  always_comb begin
    o_tdata  = '0;
    o_tvalid = 1'b0;
    o_tlast  = 1'b0;
    i_tready = 1'b0;
    unique case (state_q)
      S_HEADER: begin
        // Header waits for the packet's first sample without consuming it.
        o_tdata  = hdr_word;
        o_tvalid = i_tvalid;
      end
`ifdef CHDR_FRAMER_TIME_EN
      S_TIME: begin
        o_tdata  = time_q;
        o_tvalid = 1'b1;
      end
`endif
      S_PAYLOAD: begin
        o_tdata  = i_tdata;
        o_tvalid = i_tvalid;
        i_tready = o_tready;
        o_tlast  = last_word;
      end
      default: ;
    endcase
    if (soft_rst) begin
      o_tvalid = 1'b0;
      o_tlast  = 1'b0;
      i_tready = 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_chdr_framer.sv
// Scoreboard bench for axi_chdr_framer: stimulus pushes expected words,
// a negedge monitor pops and compares on every output handshake.
module tb_axi_chdr_framer;
`ifdef CHDR_FRAMER_TIME_EN
  localparam int HT = 1;
`else
  localparam int HT = 0;
`endif
  localparam logic [1:0] TB_PKT_TYPE = 2'b00;

  logic        clk = 1'b0;
  logic        reset, clear;
  logic [31:0] sid;
  logic [15:0] spp;
`ifdef CHDR_FRAMER_TIME_EN
  logic [63:0] vita_time;
`endif
  logic [63:0] i_tdata;
  logic        i_tvalid, i_tready;
  logic [63:0] o_tdata;
  logic        o_tlast, o_tvalid, o_tready;

  always #5 clk = ~clk;

  axi_chdr_framer #(.WIDTH(64), .PKT_TYPE(TB_PKT_TYPE)) dut (
    .clk(clk), .reset(reset), .clear(clear), .sid(sid), .spp(spp),
`ifdef CHDR_FRAMER_TIME_EN
    .vita_time(vita_time),
`endif
    .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready)
  );

  typedef struct { logic [63:0] data; logic last; } exp_t;
  exp_t        exp_q[$];
  logic [63:0] in_q[$];
  int checks = 0, failures = 0, n_hs = 0, seq_m = 0;
  bit rand_ready = 0, gap_en = 0;

  function automatic logic [63:0] hdr(input int seq, input int unsigned words);
    logic [15:0] len;
    logic [11:0] s12;
    len = 16'((words + 1 + HT) * 8);
    s12 = 12'(seq);
    return {TB_PKT_TYPE, (HT == 1), 1'b0, s12, len, sid};
  endfunction

  function automatic void push_exp(input logic [63:0] d, input logic l);
    exp_t e;
    e.data = d; e.last = l;
    exp_q.push_back(e);
  endfunction

  function automatic void push_time();
`ifdef CHDR_FRAMER_TIME_EN
    push_exp(vita_time, 1'b0);
`endif
  endfunction

  // Reference model: whole packets from the current spp/sid.
  task automatic gen_packets(input int n);
    int unsigned eff;
    logic [63:0] s;
    for (int p = 0; p < n; p++) begin
      eff = (spp == 16'd0) ? 1 : int'(spp);
      push_exp(hdr(seq_m, eff), 1'b0);
      seq_m = (seq_m + 1) % 4096;
      push_time();
      for (int unsigned w = 0; w < eff; w++) begin
        s = {$urandom, $urandom};
        in_q.push_back(s);
        push_exp(s, w == eff - 1);
      end
    end
  endtask

  // Input driver: holds each sample until consumed.
  initial begin
    i_tvalid = 1'b0;
    i_tdata  = '0;
    forever begin
      if (in_q.size() > 0) begin
        if (gap_en) repeat ($urandom_range(0, 2)) begin
          i_tvalid = 1'b0;
          @(posedge clk); #1;
        end
        i_tdata  = in_q.pop_front();
        i_tvalid = 1'b1;
        forever begin
          @(negedge clk);
          if (i_tready) break;
        end
        @(posedge clk); #1;
        i_tvalid = 1'b0;
      end else begin
        i_tvalid = 1'b0;
        @(posedge clk); #1;
      end
    end
  end

  // Output backpressure.
  initial begin
    o_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      o_tready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor: reset masking, stall stability, scoreboard compare.
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data;
  logic        prev_last;
  always @(negedge clk) begin
    exp_t e;
    if (reset || clear) begin
      checks++;
      if (o_tvalid !== 1'b0 || o_tlast !== 1'b0) begin
        failures++;
        $display("FAIL reset_mask got tvalid=%b tlast=%b required 0/0", o_tvalid, o_tlast);
      end
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (o_tvalid !== 1'b1 || o_tdata !== prev_data || o_tlast !== prev_last) begin
          failures++;
          $display("FAIL stall_stable got v=%b d=%h l=%b required v=1 d=%h l=%b",
                   o_tvalid, o_tdata, o_tlast, prev_data, prev_last);
        end
      end
      if (o_tvalid && o_tready) begin
        n_hs++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_word got d=%h l=%b required no output", o_tdata, o_tlast);
        end else begin
          e = exp_q.pop_front();
          if (o_tdata !== e.data || o_tlast !== e.last) begin
            failures++;
            $display("FAIL out_word hs=%0d got d=%h l=%b required d=%h l=%b",
                     n_hs, o_tdata, o_tlast, e.data, e.last);
          end
        end
      end
      prev_stall = o_tvalid && !o_tready;
      prev_data  = o_tdata;
      prev_last  = o_tlast;
    end
  end

  task automatic drain(input string nm);
    int k;
    for (k = 0; k < 40000 && exp_q.size() != 0; k++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_%s got pending=%0d required 0", nm, exp_q.size());
      exp_q.delete();
      in_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input bit use_clear);
    @(posedge clk); #1;
    if (use_clear) clear = 1'b1; else reset = 1'b1;
    checks++;
    if (i_tready !== 1'b0) begin
      failures++;
      $display("FAIL reset_tready got %b required 0", i_tready);
    end
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0; clear = 1'b0;
    seq_m = 0;
  endtask

  // Watchdog so a stuck DUT still ends the run.
  initial begin
    #900000;
    failures++;
    $display("FAIL watchdog got timeout required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] s[6];
    int base, k;
    reset = 1'b1; clear = 1'b0; spp = 16'd4; sid = 32'h0001_0002;
`ifdef CHDR_FRAMER_TIME_EN
    vita_time = 64'h123;
`endif
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (i_tready !== 1'b0) begin
      failures++;
      $display("FAIL init_tready got %b required 0", i_tready);
    end
    reset = 1'b0;
    seq_m = 0;

    // Two packets of spp=4, no backpressure.
    gen_packets(2);
    drain("spp4");

    // spp=1 across the full 12-bit sequence wrap.
    do_reset(1'b0);
    spp = 16'd1; sid = $urandom;
    gen_packets(4097);
    drain("wrap");

    // Random gaps and backpressure, spp=7.
    rand_ready = 1; gap_en = 1;
    spp = 16'd7; sid = $urandom;
`ifdef CHDR_FRAMER_TIME_EN
    vita_time = {$urandom, $urandom};
`endif
    gen_packets(12);
    drain("random");

    // spp=0 behaves as one payload word.
    spp = 16'd0; sid = $urandom;
    gen_packets(5);
    drain("spp0");

    // Reset after 2 of 4 payload words; the packet is abandoned.
    rand_ready = 0; gap_en = 0;
    do_reset(1'b1);
    spp = 16'd4; sid = 32'hCAFE_0042;
    base = n_hs;
    for (int i = 0; i < 6; i++) begin
      s[i] = {$urandom, $urandom};
      in_q.push_back(s[i]);
    end
    push_exp(hdr(seq_m, 4), 1'b0);
    push_time();
    push_exp(s[0], 1'b0);
    push_exp(s[1], 1'b0);
    push_exp(hdr(0, 4), 1'b0);
    push_time();
    for (int i = 2; i < 6; i++) push_exp(s[i], i == 5);
    seq_m = 1;
    for (k = 0; k < 200; k++) begin
      @(negedge clk); #1;
      if (n_hs >= base + 3 + HT) break;
    end
    checks++;
    if (n_hs < base + 3 + HT) begin
      failures++;
      $display("FAIL midreset_wait got hs=%0d required %0d", n_hs - base, 3 + HT);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b0;
    drain("midreset");

    // Length field wraps modulo 2^16 while payload keeps its full size.
    rand_ready = 1;
    spp = 16'd8191; sid = $urandom;
    gen_packets(1);
    drain("lenwrap");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
